// File: rtl/ahbl_gpio_ctrl_if.sv
// AHB-Lite slave-side bus bundle for ahbl_gpio_ctrl.
interface ahbl_gpio_ctrl_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic        HREADY;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;

  modport master (output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY, HWDATA,
                  input  HRDATA, HREADYOUT, HRESP);
  modport slave  (input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY, HWDATA,
                  output HRDATA, HREADYOUT, HRESP);
endinterface

// File: rtl/ahbl_gpio_ctrl.sv
// AHB-Lite 32-bit GPIO port: out/oe registers, set/clr/tgl aliases, synchronized input.
// Optional edge-detect interrupt unit enabled by defining GPIO_IRQ_EN.
module ahbl_gpio_ctrl #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] OUT_RESET   = 32'h0000_0000
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  ahbl_gpio_ctrl_if.slave   bus,
  output logic [31:0]       GPIO_OUT,
  output logic [31:0]       GPIO_OE,
  input  logic [31:0]       GPIO_IN,
  output logic              IRQ
);
  localparam logic [3:0] OFF_OUT = 4'h0;
  localparam logic [3:0] OFF_OE  = 4'h1;
  localparam logic [3:0] OFF_IN  = 4'h2;
  localparam logic [3:0] OFF_SET = 4'h3;
  localparam logic [3:0] OFF_CLR = 4'h4;
  localparam logic [3:0] OFF_TGL = 4'h5;

  logic        r_dp_vld, r_dp_write, r_dp_word;
  logic [3:0]  r_dp_off;
  logic [31:0] r_out, r_oe;
  logic [SYNC_STAGES-1:0][31:0] r_sync;
  logic [31:0] w_din, w_rdata;
  logic        w_wr;
  logic        w_unused;

  assign w_unused = &{bus.HADDR[31:6], bus.HADDR[1:0], bus.HTRANS[0]};

  // Data-phase latch; only word writes are allowed to touch registers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_dp_vld   <= 1'b0;
      r_dp_write <= 1'b0;
      r_dp_word  <= 1'b0;
      r_dp_off   <= '0;
    end else begin
      r_dp_vld   <= bus.HSEL & bus.HREADY & bus.HTRANS[1];
      r_dp_write <= bus.HWRITE;
      r_dp_word  <= (bus.HSIZE == 3'b010);
      r_dp_off   <= bus.HADDR[5:2];
    end
  end

  assign w_wr = r_dp_vld & r_dp_write & r_dp_word;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_out <= OUT_RESET;
      r_oe  <= '0;
    end else if (w_wr) begin
      case (r_dp_off)
        OFF_OUT: r_out <= bus.HWDATA;
        OFF_OE:  r_oe  <= bus.HWDATA;
        OFF_SET: r_out <= r_out | bus.HWDATA;
        OFF_CLR: r_out <= r_out & ~bus.HWDATA;
        OFF_TGL: r_out <= r_out ^ bus.HWDATA;
        default: ;
      endcase
    end
  end

  // The last sync stage is the only path from the pads into any logic.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) r_sync <= '0;
    else          r_sync <= {r_sync[SYNC_STAGES-2:0], GPIO_IN};
  end

  assign w_din = r_sync[SYNC_STAGES-1];

`ifdef GPIO_IRQ_EN
  localparam logic [3:0] OFF_MASK = 4'h6;
  localparam logic [3:0] OFF_EDGE = 4'h7;
  localparam logic [3:0] OFF_STAT = 4'h8;

  logic [31:0] r_din_d, r_mask, r_edge, r_status;
  logic        r_irq;
  logic [31:0] w_hit, w_w1c;

  assign w_hit = (r_edge & w_din & ~r_din_d) | (~r_edge & ~w_din & r_din_d);
  assign w_w1c = (w_wr && r_dp_off == OFF_STAT) ? bus.HWDATA : '0;

  // Hardware edges OR in after the W1C mask, so a same-cycle set wins.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_din_d  <= '0;
      r_mask   <= '0;
      r_edge   <= '0;
      r_status <= '0;
      r_irq    <= 1'b0;
    end else begin
      r_din_d  <= w_din;
      if (w_wr && r_dp_off == OFF_MASK) r_mask <= bus.HWDATA;
      if (w_wr && r_dp_off == OFF_EDGE) r_edge <= bus.HWDATA;
      r_status <= (r_status & ~w_w1c) | w_hit;
      r_irq    <= |(r_status & r_mask);
    end
  end

  assign IRQ = r_irq;
`else
  assign IRQ = 1'b0;
`endif

  always_comb begin
    w_rdata = '0;
    if (r_dp_vld && !r_dp_write) begin
      case (r_dp_off)
        OFF_OUT:  w_rdata = r_out;
        OFF_OE:   w_rdata = r_oe;
        OFF_IN:   w_rdata = w_din;
`ifdef GPIO_IRQ_EN
        OFF_MASK: w_rdata = r_mask;
        OFF_EDGE: w_rdata = r_edge;
        OFF_STAT: w_rdata = r_status;
`endif
        default:  w_rdata = '0;
      endcase
    end
  end

  assign bus.HRDATA    = w_rdata;
  assign bus.HREADYOUT = 1'b1;
  assign bus.HRESP     = 1'b0;
  assign GPIO_OUT      = r_out;
  assign GPIO_OE       = r_oe;
endmodule
